// File: rtl/tone_mixer_stereo_pkg.sv
// Shared constants and helpers for the stereo tone mixer: sample range,
// amplitude shift derivation and output saturation.
package tone_mixer_pkg;

  localparam int SAMPLE_W = 16;
  localparam logic signed [15:0] SAMPLE_MAX = 16'sh7FFF;
  localparam logic signed [15:0] SAMPLE_MIN = 16'sh8000;

  // Left shift applied to an envelope value so that NUM_CH full-scale
  // channels just fit into a 16-bit sample. Clamped at 0 for very wide
  // volumes, which is the only way the mix can exceed the sample range.
  function automatic int amp_shift(input int vol_w, input int num_ch);
    int sh;
    sh = 15 - vol_w - $clog2(num_ch);
    return (sh < 0) ? 0 : sh;
  endfunction

  // Width of the signed per-channel contribution and the mix accumulator.
  // 16 + log2(NUM_CH) normally; grows when the shift had to be clamped.
  function automatic int acc_width(input int vol_w, input int num_ch);
    int mag_w;
    mag_w = vol_w + amp_shift(vol_w, num_ch) + 1;
    return ((mag_w > SAMPLE_W) ? mag_w : SAMPLE_W) + $clog2(num_ch);
  endfunction

  // Clip a sign-extended mix sum into the signed 16-bit sample range.
  function automatic logic signed [15:0] sat_sample(input logic signed [31:0] acc);
    if (acc > 32'sd32767) begin
      return SAMPLE_MAX;
    end else if (acc < -32'sd32768) begin
      return SAMPLE_MIN;
    end else begin
      return acc[15:0];
    end
  endfunction

endpackage

// File: rtl/tone_mixer_stereo_if.sv
// Control and sample bundle between the tone mixer and its host/DAC side.
interface tone_mixer_stereo_if #(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 22,
  parameter int VOL_W  = 4
);
  import tone_mixer_pkg::*;

  logic [NUM_CH*DIV_W-1:0]    note_div;
  logic [NUM_CH*VOL_W-1:0]    vol;
  logic [NUM_CH-1:0]          load;
  logic [NUM_CH-1:0]          decay_en;
  logic [NUM_CH-1:0]          pan_l;
  logic [NUM_CH-1:0]          pan_r;
  logic signed [SAMPLE_W-1:0] audio_left;
  logic signed [SAMPLE_W-1:0] audio_right;
  logic [NUM_CH-1:0]          active;

  modport master (
    output note_div, vol, load, decay_en, pan_l, pan_r,
    input  audio_left, audio_right, active
  );

  modport slave (
    input  note_div, vol, load, decay_en, pan_l, pan_r,
    output audio_left, audio_right, active
  );

endinterface

// File: rtl/tone_mixer_stereo_channel.sv
// One square-wave tone channel: latched divider, phase toggle and a
// linear decay envelope. Produces a signed contribution to the mix.
module tone_channel
  import tone_mixer_pkg::*;
#(
  parameter int DIV_W = 22,
  parameter int VOL_W = 4,
  parameter int SH    = 9,
  parameter int CON_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic                    tick,
  input  logic                    decay_en,
  input  logic [DIV_W-1:0]        note_div,
  input  logic [VOL_W-1:0]        vol,
  output logic signed [CON_W-1:0] contrib,
  output logic                    active
);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt;
  logic             phase;
  logic [VOL_W-1:0] env;
  logic [CON_W-1:0] amp;

  // Divider: load restarts the note, a zero divider parks the channel in rest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      cnt   <= '0;
      phase <= 1'b0;
    end else if (load) begin
      div_q <= note_div;
      cnt   <= '0;
      phase <= 1'b0;
    end else if (div_q == '0) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (cnt == div_q) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Envelope: load beats a coincident decay tick; decay stops at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      env <= '0;
    end else if (load) begin
      env <= vol;
    end else if (tick && decay_en && (env != '0)) begin
      env <= env - 1'b1;
    end
  end

  assign amp    = CON_W'(env) << SH;
  assign active = (div_q != '0) && (env != '0);

  // Square wave: positive half while phase is high, silent when inactive.
  always_comb begin
    if (!active) begin
      contrib = '0;
    end else if (phase) begin
      contrib = signed'(amp);
    end else begin
      contrib = -signed'(amp);
    end
  end

endmodule

// File: rtl/tone_mixer_stereo.sv
// Multi-channel square-wave tone mixer with per-channel pan and decay,
// producing saturated, registered signed 16-bit stereo samples.
module tone_mixer_stereo
  import tone_mixer_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int DIV_W     = 22,
  parameter int VOL_W     = 4,
  parameter int DECAY_DIV = 1000000
) (
  input  logic                clk,
  input  logic                rst_n,
  tone_mixer_stereo_if.slave  bus
);

  localparam int SH    = amp_shift(VOL_W, NUM_CH);
  localparam int ACC_W = acc_width(VOL_W, NUM_CH);
  localparam int PRE_W = $clog2(DECAY_DIV);

  logic [PRE_W-1:0]        pre;
  logic                    tick;
  logic signed [ACC_W-1:0] contrib [NUM_CH];
  logic [NUM_CH-1:0]       act;
  logic signed [ACC_W-1:0] sum_l;
  logic signed [ACC_W-1:0] sum_r;

  assign tick = (pre == PRE_W'(DECAY_DIV - 1));

  // Decay prescaler: free-running 0..DECAY_DIV-1, tick on the wrap cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre <= '0;
    end else if (tick) begin
      pre <= '0;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    tone_channel #(
      .DIV_W (DIV_W),
      .VOL_W (VOL_W),
      .SH    (SH),
      .CON_W (ACC_W)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (bus.load[i]),
      .tick     (tick),
      .decay_en (bus.decay_en[i]),
      .note_div (bus.note_div[i*DIV_W +: DIV_W]),
      .vol      (bus.vol[i*VOL_W +: VOL_W]),
      .contrib  (contrib[i]),
      .active   (act[i])
    );
  end

  assign bus.active = act;

  // Pan gating and summation; the accumulator is wide enough never to wrap.
  always_comb begin
    sum_l = '0;
    sum_r = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.pan_l[i]) sum_l = sum_l + contrib[i];
      if (bus.pan_r[i]) sum_r = sum_r + contrib[i];
    end
  end

  // Output sample registers, clipped to the signed 16-bit range.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.audio_left  <= '0;
      bus.audio_right <= '0;
    end else begin
      bus.audio_left  <= sat_sample(32'(sum_l));
      bus.audio_right <= sat_sample(32'(sum_r));
    end
  end

endmodule

// File: tb/tb_tone_mixer_stereo.sv
// Self-checking bench for tone_mixer_stereo: a 4-channel instance with a
// fast decay prescaler checked against a closed-form note/envelope model,
// plus two 2-channel instances exercising the mix range and clipping.
module tb_tone_mixer_stereo;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_cmp;
  int   n_err;

  tone_mixer_stereo_if #(.NUM_CH(4), .DIV_W(22), .VOL_W(4))  if4 ();
  tone_mixer_stereo_if #(.NUM_CH(2), .DIV_W(8),  .VOL_W(4))  if2 ();
  tone_mixer_stereo_if #(.NUM_CH(2), .DIV_W(8),  .VOL_W(15)) ifs ();

  tone_mixer_stereo #(.NUM_CH(4), .DIV_W(22), .VOL_W(4), .DECAY_DIV(8))
    dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  tone_mixer_stereo #(.NUM_CH(2), .DIV_W(8), .VOL_W(4), .DECAY_DIV(16))
    dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));
  tone_mixer_stereo #(.NUM_CH(2), .DIV_W(8), .VOL_W(15), .DECAY_DIV(16))
    duts (.clk(clk), .rst_n(rst_n), .bus(ifs));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge index since reset release; edge 1 is the first active edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Bench-side configuration and the values captured at each load.
  int cfg_div [4];
  int cfg_vol [4];
  bit cfg_dec [4];
  bit cfg_pl  [4];
  bit cfg_pr  [4];
  int ld_edge [4];
  int ld_div  [4];
  int ld_vol  [4];
  bit ld_dec  [4];
  bit loaded  [4];

  localparam int DECAY = 8;
  localparam int AMP1  = 512;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int sat16(input int v);
    return (v > 32767) ? 32767 : ((v < -32768) ? -32768 : v);
  endfunction

  // Envelope after edge m: start volume minus decay ticks since the load.
  function automatic int model_env(input int c, input int m);
    int t;
    t = ld_dec[c] ? (m / DECAY - ld_edge[c] / DECAY) : 0;
    return (ld_vol[c] > t) ? ld_vol[c] - t : 0;
  endfunction

  // Channel output after edge m: square wave of half-period div+1 starting low.
  function automatic int model_contrib(input int c, input int m);
    int e;
    int k;
    if (!loaded[c] || m < ld_edge[c] || ld_div[c] == 0) return 0;
    e = model_env(c, m);
    if (e == 0) return 0;
    k = m - ld_edge[c];
    return (((k / (ld_div[c] + 1)) % 2) == 1) ? e * AMP1 : -e * AMP1;
  endfunction

  // Sample seen after edge n reflects channel state after edge n-1.
  function automatic int exp_side(input int n, input bit is_r);
    int s;
    s = 0;
    for (int c = 0; c < 4; c++)
      if (is_r ? cfg_pr[c] : cfg_pl[c]) s += model_contrib(c, n - 1);
    return sat16(s);
  endfunction

  function automatic logic [3:0] exp_active(input int n);
    logic [3:0] a;
    a = '0;
    for (int c = 0; c < 4; c++)
      a[c] = loaded[c] && (n >= ld_edge[c]) && (ld_div[c] != 0) && (model_env(c, n) != 0);
    return a;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int c, input int d, input int v, input bit dec,
                        input bit pl, input bit pr);
    cfg_div[c] = d;
    cfg_vol[c] = v;
    cfg_dec[c] = dec;
    cfg_pl[c]  = pl;
    cfg_pr[c]  = pr;
    if4.note_div[c*22 +: 22] = 22'(d);
    if4.vol[c*4 +: 4]        = 4'(v);
    if4.decay_en[c]          = dec;
    if4.pan_l[c]             = pl;
    if4.pan_r[c]             = pr;
  endtask

  task automatic do_load(input logic [3:0] mask);
    if4.load = mask;
    step();
    for (int c = 0; c < 4; c++) begin
      if (mask[c]) begin
        ld_edge[c] = cyc;
        ld_div[c]  = cfg_div[c];
        ld_vol[c]  = cfg_vol[c];
        ld_dec[c]  = cfg_dec[c];
        loaded[c]  = 1'b1;
      end
    end
    if4.load = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int c = 0; c < 4; c++) begin
      set_ch(c, 0, 0, 1'b0, 1'b0, 1'b0);
      loaded[c] = 1'b0;
    end
    if4.load = '0;
    if2.note_div = '0; if2.vol = '0; if2.load = '0;
    if2.decay_en = '0; if2.pan_l = '0; if2.pan_r = '0;
    ifs.note_div = '0; ifs.vol = '0; ifs.load = '0;
    ifs.decay_en = '0; ifs.pan_l = '0; ifs.pan_r = '0;
    #10;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (if4.audio_left !== 16'sd0 || if4.audio_right !== 16'sd0 || if4.active !== 4'b0) begin
      n_err++;
      $display("FAIL reset_state got L=%0d R=%0d act=%b want 0 0 0000",
               if4.audio_left, if4.audio_right, if4.active);
    end
    set_ch(0, 4, 15, 1'b0, 1'b1, 1'b1);
    set_ch(1, 2, 7, 1'b0, 1'b1, 1'b0);
    do_load(4'b0011);
    repeat (13) step();
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (if4.audio_left !== 16'sd0 || if4.audio_right !== 16'sd0 || if4.active !== 4'b0) begin
      n_err++;
      $display("FAIL reset_mid_note got L=%0d R=%0d act=%b want 0 0 0000",
               if4.audio_left, if4.audio_right, if4.active);
    end
    loaded[0] = 1'b0;
    loaded[1] = 1'b0;
    #4;
    rst_n = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      step();
      n_cmp++;
      if (if4.audio_left !== 16'sd0 || if4.audio_right !== 16'sd0 || if4.active !== 4'b0) begin
        n_err++;
        $display("FAIL reset_idle k=%0d got L=%0d R=%0d act=%b want 0 0 0000",
                 k, if4.audio_left, if4.audio_right, if4.active);
      end
    end
  endtask

  task automatic test_single_tone();
    int want;
    do_reset();
    set_ch(0, 4, 15, 1'b0, 1'b1, 1'b1);
    do_load(4'b0001);
    n_cmp++;
    if (if4.audio_left !== 16'sd0) begin
      n_err++;
      $display("FAIL tone_pre_latency got %0d want 0", if4.audio_left);
    end
    for (int k = 0; k < 30; k++) begin
      step();
      want = (((k / 5) % 2) == 1) ? 7680 : -7680;
      n_cmp++;
      if (int'(if4.audio_left) !== want || int'(if4.audio_right) !== want || if4.active !== 4'b0001) begin
        n_err++;
        $display("FAIL single_tone k=%0d got L=%0d R=%0d act=%b want %0d act=0001",
                 k, if4.audio_left, if4.audio_right, if4.active, want);
      end
    end
  endtask

  task automatic test_rest_reload();
    int el, er;
    logic [3:0] ea;
    do_reset();
    set_ch(0, 4, 15, 1'b0, 1'b1, 1'b1);
    do_load(4'b0001);
    for (int k = 0; k < 60; k++) begin
      if (k == 20) set_ch(0, 2, 15, 1'b0, 1'b1, 1'b1);
      if (k == 40) begin
        set_ch(0, 0, 15, 1'b0, 1'b1, 1'b1);
        do_load(4'b0001);
      end
      step();
      el = exp_side(cyc, 1'b0);
      er = exp_side(cyc, 1'b1);
      ea = exp_active(cyc);
      n_cmp++;
      if (int'(if4.audio_left) !== el || int'(if4.audio_right) !== er || if4.active !== ea) begin
        n_err++;
        $display("FAIL rest_reload k=%0d got L=%0d R=%0d act=%b want L=%0d R=%0d act=%b",
                 k, if4.audio_left, if4.audio_right, if4.active, el, er, ea);
      end
    end
    n_cmp++;
    if (if4.active[0] !== 1'b0 || if4.audio_left !== 16'sd0) begin
      n_err++;
      $display("FAIL rest_silent got L=%0d act0=%b want 0 0", if4.audio_left, if4.active[0]);
    end
  endtask

  task automatic test_decay();
    int el, er, v, last;
    logic [3:0] ea;
    int mags[$];
    do_reset();
    set_ch(0, 4, 3, 1'b1, 1'b1, 1'b1);
    do_load(4'b0001);
    last = -1;
    for (int k = 0; k < 60; k++) begin
      step();
      el = exp_side(cyc, 1'b0);
      er = exp_side(cyc, 1'b1);
      ea = exp_active(cyc);
      v = iabs(int'(if4.audio_left));
      if (v != last) begin
        mags.push_back(v);
        last = v;
      end
      n_cmp++;
      if (int'(if4.audio_left) !== el || int'(if4.audio_right) !== er || if4.active !== ea) begin
        n_err++;
        $display("FAIL decay k=%0d got L=%0d R=%0d act=%b want L=%0d R=%0d act=%b",
                 k, if4.audio_left, if4.audio_right, if4.active, el, er, ea);
      end
    end
    n_cmp++;
    if (mags.size() != 4 || mags[0] != 1536 || mags[1] != 1024 || mags[2] != 512 || mags[3] != 0) begin
      n_err++;
      $display("FAIL decay_steps got %0d levels %p want 1536 1024 512 0", mags.size(), mags);
    end
    // Reload at a decay tick while the envelope is still non-zero.
    set_ch(0, 4, 9, 1'b1, 1'b1, 1'b1);
    do_load(4'b0001);
    while (((cyc + 1) % DECAY) != 0) step();
    set_ch(0, 4, 5, 1'b1, 1'b1, 1'b1);
    do_load(4'b0001);
    step();
    n_cmp++;
    if (iabs(int'(if4.audio_left)) !== 2560 || if4.active[0] !== 1'b1) begin
      n_err++;
      $display("FAIL load_vs_tick got |L|=%0d act0=%b want 2560 1",
               iabs(int'(if4.audio_left)), if4.active[0]);
    end
    for (int k = 0; k < 30; k++) begin
      step();
      el = exp_side(cyc, 1'b0);
      ea = exp_active(cyc);
      n_cmp++;
      if (int'(if4.audio_left) !== el || if4.active !== ea) begin
        n_err++;
        $display("FAIL decay_reload k=%0d got L=%0d act=%b want L=%0d act=%b",
                 k, if4.audio_left, if4.active, el, ea);
      end
    end
  endtask

  task automatic test_pan_mix();
    int el, er;
    logic [3:0] ea;
    do_reset();
    set_ch(0, 3, 10, 1'b0, 1'b1, 1'b0);
    set_ch(1, 3, 10, 1'b0, 1'b0, 1'b1);
    do_load(4'b0011);
    for (int k = 0; k < 24; k++) begin
      step();
      el = exp_side(cyc, 1'b0);
      er = exp_side(cyc, 1'b1);
      ea = exp_active(cyc);
      n_cmp++;
      if (int'(if4.audio_left) !== el || int'(if4.audio_right) !== er || if4.active !== ea) begin
        n_err++;
        $display("FAIL pan k=%0d got L=%0d R=%0d act=%b want L=%0d R=%0d act=%b",
                 k, if4.audio_left, if4.audio_right, if4.active, el, er, ea);
      end
    end
    do_reset();
    for (int c = 0; c < 4; c++) set_ch(c, 5, 15, 1'b0, 1'b1, 1'b1);
    do_load(4'b1111);
    step();
    n_cmp++;
    if (int'(if4.audio_left) !== -30720 || int'(if4.audio_right) !== -30720) begin
      n_err++;
      $display("FAIL full_mix got L=%0d R=%0d want -30720", if4.audio_left, if4.audio_right);
    end
    for (int k = 0; k < 24; k++) begin
      step();
      el = exp_side(cyc, 1'b0);
      n_cmp++;
      if (int'(if4.audio_left) !== el || int'(if4.audio_right) !== el) begin
        n_err++;
        $display("FAIL full_mix k=%0d got L=%0d R=%0d want %0d",
                 k, if4.audio_left, if4.audio_right, el);
      end
    end
  endtask

  task automatic test_random_mix();
    int el, er;
    logic [3:0] ea;
    do_reset();
    for (int r = 0; r < 12; r++) begin
      int c;
      c = r % 4;
      set_ch(c, int'($urandom_range(0, 12)), int'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      do_load(4'(1 << c));
      for (int k = 0; k < int'($urandom_range(5, 40)); k++) begin
        step();
        el = exp_side(cyc, 1'b0);
        er = exp_side(cyc, 1'b1);
        ea = exp_active(cyc);
        n_cmp++;
        if (int'(if4.audio_left) !== el || int'(if4.audio_right) !== er || if4.active !== ea) begin
          n_err++;
          $display("FAIL random r=%0d k=%0d got L=%0d R=%0d act=%b want L=%0d R=%0d act=%b",
                   r, k, if4.audio_left, if4.audio_right, if4.active, el, er, ea);
        end
      end
    end
  endtask

  task automatic test_saturation();
    int w2l, w2r, wsl, wsr;
    bit ph;
    do_reset();
    if2.note_div = {8'd3, 8'd3};
    if2.vol      = {4'd15, 4'd15};
    if2.pan_l    = 2'b01;
    if2.pan_r    = 2'b11;
    ifs.note_div = {8'd3, 8'd3};
    ifs.vol      = {15'd32767, 15'd32767};
    ifs.pan_l    = 2'b11;
    ifs.pan_r    = 2'b01;
    if2.load = 2'b11;
    ifs.load = 2'b11;
    step();
    if2.load = 2'b00;
    ifs.load = 2'b00;
    for (int k = 0; k < 16; k++) begin
      step();
      ph  = ((k / 4) % 2) == 1;
      w2l = ph ? 15360 : -15360;
      w2r = ph ? 30720 : -30720;
      wsl = ph ? 32767 : -32768;
      wsr = ph ? 32767 : -32767;
      n_cmp++;
      if (int'(if2.audio_left) !== w2l || int'(if2.audio_right) !== w2r || if2.active !== 2'b11) begin
        n_err++;
        $display("FAIL mix2 k=%0d got L=%0d R=%0d act=%b want L=%0d R=%0d act=11",
                 k, if2.audio_left, if2.audio_right, if2.active, w2l, w2r);
      end
      n_cmp++;
      if (int'(ifs.audio_left) !== wsl || int'(ifs.audio_right) !== wsr || ifs.active !== 2'b11) begin
        n_err++;
        $display("FAIL saturate k=%0d got L=%0d R=%0d act=%b want L=%0d R=%0d act=11",
                 k, ifs.audio_left, ifs.audio_right, ifs.active, wsl, wsr);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    #3;
    test_reset();
    test_single_tone();
    test_rest_reload();
    test_decay();
    test_pan_mix();
    test_random_mix();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tone_mixer_stereo.md
Name: tone_mixer_stereo

Overview:
- Parametrised successor to the single-channel square-wave buzzer driver.
- NUM_CH independent square-wave tone channels, each with:
  - a latched note divider
  - a per-channel volume and an optional linear decay envelope
  - left/right pan enables
- Channels are summed with saturation into registered signed 16-bit left and right samples, which feed the audio DAC serialiser.

Parameters:
- NUM_CH, 4, number of tone channels (power of two, 1..8).
- DIV_W, 22, note divider width.
- VOL_W, 4, volume/envelope width.
- DECAY_DIV, 1000000, clk cycles per envelope decay step (≥ 2).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset.
- note_div  in  NUM_CH*DIV_W  per-channel half-period minus one; channel i at [i*DIV_W +: DIV_W].
- vol  in  NUM_CH*VOL_W  per-channel start volume, sampled on load.
- load  in  NUM_CH  per-channel one-cycle strobe: latch note_div/vol, restart channel.
- decay_en  in  NUM_CH  per-channel: envelope decays while high.
- pan_l  in  NUM_CH  channel i contributes to left when 1.
- pan_r  in  NUM_CH  channel i contributes to right when 1.
- audio_left  out  16  signed two's-complement left sample.
- audio_right  out  16  signed two's-complement right sample.
- active  out  NUM_CH  channel i sounding (latched div ≠ 0 and env ≠ 0).

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk.
  - All divider counters, phases, envelopes, latched divs and the decay prescaler clear to 0.
  - audio_left = audio_right = 16'h0000; active = 0.
- Per channel, on a load[i] cycle:
  - div_q ← note_div slice, env ← vol slice, cnt ← 0, phase ← 0.
  - Changes on note_div/vol without load are ignored.
- Divider when div_q ≠ 0:
  - If cnt == div_q: cnt ← 0 and phase toggles; else cnt ← cnt+1.
  - Half-period = div_q+1 cycles; full period = 2*(div_q+1).
- div_q == 0 (rest): cnt and phase held at 0; contribution is 0.
- Decay prescaler: free-running counter 0..DECAY_DIV-1; tick asserted one cycle when it wraps.
  - On tick, each channel with decay_en=1 and env>0 does env ← env-1.
  - env saturates at 0, never wraps.
- Simultaneous load and tick on a channel: load wins (env = new vol).
- Amplitude:
  - amp_i = env_i << SH, with SH = 15 - VOL_W - log2(NUM_CH) (=9 at defaults).
  - Contribution = +amp_i when phase=1, -amp_i when phase=0, 0 when div_q=0 or env=0.
- Mixing:
  - Left = sum of contributions with pan_l=1; right likewise with pan_r=1.
  - Sum width 16+log2(NUM_CH) bits, saturated to [-32768, 32767].
- Latency: audio_* registered; a sample at cycle n+1 reflects phase/env/pan state at cycle n.
- active is combinational from registered div_q/env.
- Reset mid-note: immediate silence; no load is required afterwards to stay silent.

Decomposition:
- Package tone_mixer_pkg:
  - SAMPLE_W=16, SAMPLE_MAX=16'sh7FFF, SAMPLE_MIN=16'sh8000
  - function computing SH from VOL_W/NUM_CH
  - helper function for saturating the sum.
- Sub-module tone_channel, instantiated NUM_CH times in a generate loop.
  - Contains: div_q, cnt, phase, env; load/tick handling.
  - Outputs: signed contribution and active.
- Top contains: decay prescaler, pan gating, adders, saturation, output registers.

Test Plan:
- Reset / idle: assert rst_n=0 mid-activity → audio_left=audio_right=0 and active=0 at once; with no load after release, outputs stay 0 for 1000 cycles.
- Single tone:
  - Stimulus: ch0 load, note_div=4, vol=15, pan_l=pan_r=1, decay_en=0.
  - Required: outputs alternate -7680/+7680 with 5-cycle halves, first half negative, a 10-cycle period, and the first sample one cycle after load.
- Rest and reload:
  - Load ch0 with note_div=0 → ch0 contributes 0 and active[0]=0.
  - Change note_div without load → no frequency change.
- Decay (DECAY_DIV=8 in bench):
  - Stimulus: vol=3, decay_en=1.
  - Required: amplitude steps 1536 → 1024 → 512 → 0 on successive ticks, active drops, and env holds at 0.
  - Load coinciding with a tick → env=new vol.
- Pan and mix:
  - Stimulus: ch0 pan_l only, ch1 pan_r only, equal div/vol.
  - Required: left carries ch0 only and right carries ch1 only.
  - All 4 channels in phase at vol=15 → ±30720, no saturation.
- Saturation: with NUM_CH=2, VOL_W=4 (SH=10, amp 15360) plus a forced-overflow configuration → sum clipped to exactly 32767/-32768 with no wrap.
